// File: rtl/merge_sequencer.sv
// Sequencer for one radix-RADIX merge on a registered merger tree: holds one head per lane,
// strobes the merger, pops the winning lane and emits the ascending stream over valid/ready.
module merge_sequencer #(
  parameter int COORD_BITS = 8,
  parameter int RADIX      = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic [RADIX-1:0]              lane_en_i,
  input  logic [RADIX-1:0]              lane_valid_i,
  input  logic [RADIX*COORD_BITS-1:0]   lane_coord_i,
  input  logic [RADIX-1:0]              lane_last_i,
  output logic [RADIX-1:0]              lane_ready_o,
  output logic [RADIX*COORD_BITS-1:0]   mrg_coord_in_o,
  output logic                          mrg_selected_o,
  input  logic [COORD_BITS-1:0]         mrg_coord_i,
  input  logic [RADIX-1:0]              mrg_fetch_next_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [COORD_BITS-1:0]         out_coord_o,
  output logic                          out_last_o,
  output logic [CNT_BITS-1:0]           elem_count_o,
  output logic                          done_o,
  output logic                          err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [COORD_BITS-1:0] SENTINEL = {COORD_BITS{1'b1}};

  state_e                              state_q, state_d;
  logic [RADIX-1:0][COORD_BITS-1:0]    head_coord_q, head_coord_d;
  logic [RADIX-1:0]                    head_full_q, head_full_d;
  logic [RADIX-1:0]                    head_last_q, head_last_d;
  logic [RADIX-1:0]                    lane_done_q, lane_done_d;
  logic [COORD_BITS-1:0]               out_coord_q, out_coord_d;
  logic                                out_last_q, out_last_d;
  logic [CNT_BITS-1:0]                 elem_count_q, elem_count_d;
  logic                                err_q, err_d;

  logic [RADIX-1:0]                    accept_s;
  logic                                sentinel_hit_s;
  logic                                win_last_s;
  logic                                others_done_s;

  function automatic logic is_onehot(input logic [RADIX-1:0] v);
    return (v != '0) && ((v & (v - {{(RADIX-1){1'b0}}, 1'b1})) == '0);
  endfunction

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      head_coord_q <= '0;
      head_full_q  <= '0;
      head_last_q  <= '0;
      lane_done_q  <= '0;
      out_coord_q  <= '0;
      out_last_q   <= 1'b0;
      elem_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_coord_q <= head_coord_d;
      head_full_q  <= head_full_d;
      head_last_q  <= head_last_d;
      lane_done_q  <= lane_done_d;
      out_coord_q  <= out_coord_d;
      out_last_q   <= out_last_d;
      elem_count_q <= elem_count_d;
      err_q        <= err_d;
    end
  end

  // Ready and merger inputs depend on registered state only, never on lane inputs.
  always_comb begin
    lane_ready_o   = '0;
    mrg_coord_in_o = {(RADIX*COORD_BITS){1'b1}};
    if (state_q == S_FILL) begin
      lane_ready_o = ~head_full_q & ~lane_done_q;
    end else begin
      lane_ready_o = '0;
    end
    for (int i = 0; i < RADIX; i++) begin
      if (head_full_q[i]) begin
        mrg_coord_in_o[i*COORD_BITS +: COORD_BITS] = head_coord_q[i];
      end else begin
        mrg_coord_in_o[i*COORD_BITS +: COORD_BITS] = SENTINEL;
      end
    end
  end

  always_comb begin
    accept_s       = lane_valid_i & lane_ready_o;
    sentinel_hit_s = 1'b0;
    for (int i = 0; i < RADIX; i++) begin
      if (accept_s[i] && (lane_coord_i[i*COORD_BITS +: COORD_BITS] == SENTINEL)) begin
        sentinel_hit_s = 1'b1;
      end else begin
        sentinel_hit_s = sentinel_hit_s;
      end
    end
    win_last_s    = |(mrg_fetch_next_i & head_last_q);
    others_done_s = &(lane_done_q | mrg_fetch_next_i);
  end

  always_comb begin
    state_d      = state_q;
    head_coord_d = head_coord_q;
    head_full_d  = head_full_q;
    head_last_d  = head_last_q;
    lane_done_d  = lane_done_q;
    out_coord_d  = out_coord_q;
    out_last_d   = out_last_q;
    elem_count_d = elem_count_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          head_full_d  = '0;
          head_last_d  = '0;
          lane_done_d  = ~lane_en_i;
          elem_count_d = '0;
          err_d        = 1'b0;
          out_last_d   = 1'b0;
          state_d      = S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        for (int i = 0; i < RADIX; i++) begin
          if (accept_s[i]) begin
            head_coord_d[i] = lane_coord_i[i*COORD_BITS +: COORD_BITS];
            head_full_d[i]  = 1'b1;
            head_last_d[i]  = lane_last_i[i];
          end else begin
            head_full_d[i]  = head_full_q[i];
          end
        end
        // Heads accepted this cycle count toward readiness so an element needs only 4 cycles.
        if (sentinel_hit_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (&(head_full_d | lane_done_q)) begin
          state_d = (&lane_done_q) ? S_DONE : S_ISSUE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (is_onehot(mrg_fetch_next_i)) begin
          out_coord_d = mrg_coord_i;
          head_full_d = head_full_q & ~mrg_fetch_next_i;
          lane_done_d = lane_done_q | (mrg_fetch_next_i & head_last_q);
          out_last_d  = win_last_s & others_done_s;
          state_d     = S_EMIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          elem_count_d = elem_count_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
          state_d      = out_last_q ? S_DONE : S_FILL;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mrg_selected_o = (state_q == S_ISSUE);
  assign out_valid_o    = (state_q == S_EMIT);
  assign done_o         = (state_q == S_DONE);
  assign out_coord_o    = out_coord_q;
  assign out_last_o     = out_last_q;
  assign elem_count_o   = elem_count_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_merge_sequencer.sv
// Directed bench for merge_sequencer: a behavioural registered merger plus per-lane
// head queues, with one task per scenario doing its own checks.
module tb_merge_sequencer;
  localparam int CB = 8;
  localparam int RX = 4;
  localparam int CW = 16;

  logic              clock = 1'b0;
  logic              reset_i;
  logic              start_i;
  logic [RX-1:0]     lane_en_i;
  logic [RX-1:0]     lane_valid_i;
  logic [RX*CB-1:0]  lane_coord_i;
  logic [RX-1:0]     lane_last_i;
  logic [RX-1:0]     lane_ready_o;
  logic [RX*CB-1:0]  mrg_coord_in_o;
  logic              mrg_selected_o;
  logic [CB-1:0]     m_coord;
  logic [RX-1:0]     m_fetch;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CB-1:0]     out_coord_o;
  logic              out_last_o;
  logic [CW-1:0]     elem_count_o;
  logic              done_o;
  logic              err_o;

  always #5 clock = ~clock;

  merge_sequencer #(.COORD_BITS(CB), .RADIX(RX), .CNT_BITS(CW)) dut (
    .clock_i(clock), .reset_i(reset_i), .start_i(start_i), .lane_en_i(lane_en_i),
    .lane_valid_i(lane_valid_i), .lane_coord_i(lane_coord_i), .lane_last_i(lane_last_i),
    .lane_ready_o(lane_ready_o), .mrg_coord_in_o(mrg_coord_in_o), .mrg_selected_o(mrg_selected_o),
    .mrg_coord_i(m_coord), .mrg_fetch_next_i(m_fetch), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_coord_o(out_coord_o), .out_last_o(out_last_o),
    .elem_count_o(elem_count_o), .done_o(done_o), .err_o(err_o));

  // Merger tree: minimum wins, equal values go to the higher lane index.
  function automatic int pick(input logic [RX*CB-1:0] c);
    int b = 0;
    for (int i = 1; i < RX; i++) if (c[i*CB +: CB] <= c[b*CB +: CB]) b = i;
    return b;
  endfunction

  always @(posedge clock) begin
    if (reset_i) begin
      m_coord <= '0;
      m_fetch <= '0;
    end else if (mrg_selected_o) begin
      m_coord <= mrg_coord_in_o[pick(mrg_coord_in_o)*CB +: CB];
      m_fetch <= 4'b0001 << pick(mrg_coord_in_o);
    end
  end

  logic [CB-1:0] lv[RX][4];
  int            ln[RX];
  int            ptr[RX];
  logic [CB-1:0] beats[$];
  bit            lasts[$];
  int            done_cnt, done_cyc, valid_cnt, stall_bad, stall_cycles;
  logic [CB-1:0] stall_coord;
  bit            timed_out, done_after;
  int            n_checks = 0;
  int            n_fail = 0;

  logic [CB-1:0] exp1[7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  logic [CB-1:0] exp6[5] = '{8'd3, 8'd3, 8'd4, 8'd9, 8'd9};

  task automatic set_lane(input int i, input int n, input logic [CB-1:0] a, input logic [CB-1:0] b);
    ln[i] = n; lv[i][0] = a; lv[i][1] = b; lv[i][2] = 8'd0; lv[i][3] = 8'd0;
  endtask

  task automatic load_case1();
    set_lane(0, 2, 8'd1, 8'd5); set_lane(1, 2, 8'd2, 8'd6);
    set_lane(2, 1, 8'd3, 8'd0); set_lane(3, 2, 8'd4, 8'd7);
  endtask

  // Drives lanes/start/out_ready each negedge; handshakes seen here complete on the next posedge.
  task automatic run_merge(input logic [RX-1:0] en, input int stall_beat, input int stall_len,
                           input int gate_lane, input int gate_per, input int abort_issue, input int max_cyc);
    int stalled = 0;
    int sel_cnt = 0;
    bit abort_now = 1'b0;
    beats.delete(); lasts.delete();
    done_cnt = 0; done_cyc = -1; valid_cnt = 0; stall_bad = 0; timed_out = 1'b1; stall_coord = '0;
    for (int i = 0; i < RX; i++) ptr[i] = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clock);
      if (abort_now) begin
        reset_i = 1'b1; start_i = 1'b0; lane_valid_i = '0;
        @(negedge clock); #1;
        timed_out = 1'b0;
        return;
      end
      start_i = (cyc == 0);
      lane_en_i = en;
      for (int i = 0; i < RX; i++) begin
        if (ptr[i] < ln[i] && (gate_lane != i || cyc % gate_per == 0)) begin
          lane_valid_i[i] = 1'b1;
          lane_coord_i[i*CB +: CB] = lv[i][ptr[i]];
          lane_last_i[i] = (ptr[i] == ln[i] - 1);
        end else begin
          lane_valid_i[i] = 1'b0;
          lane_coord_i[i*CB +: CB] = 8'd0;
          lane_last_i[i] = 1'b0;
        end
      end
      out_ready_i = !(stall_beat >= 0 && beats.size() == stall_beat && stalled < stall_len);
      #1;
      if (mrg_selected_o) begin
        sel_cnt++;
        if (sel_cnt == abort_issue) abort_now = 1'b1;
      end
      if (out_valid_o) begin
        valid_cnt++;
        if (!out_ready_i) begin
          if (stalled == 0) stall_coord = out_coord_o;
          else if (out_coord_o !== stall_coord) stall_bad++;
          if (lane_ready_o !== 4'b0000) stall_bad++;
          stalled++;
        end else begin
          beats.push_back(out_coord_o);
          lasts.push_back(out_last_o);
        end
      end
      for (int i = 0; i < RX; i++) if (lane_valid_i[i] && lane_ready_o[i]) ptr[i]++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        timed_out = 1'b0;
        break;
      end
    end
    stall_cycles = stalled;
    @(negedge clock);
    start_i = 1'b0; lane_valid_i = '0; out_ready_i = 1'b1;
    #1;
    done_after = done_o;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; lane_en_i = '0; lane_valid_i = '0;
    lane_coord_i = '0; lane_last_i = '0; out_ready_i = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if ({lane_ready_o, mrg_selected_o, out_valid_o, out_last_o, done_o, err_o} !== 9'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {lane_ready_o, mrg_selected_o, out_valid_o, out_last_o, done_o, err_o}); end
    n_checks++; if ({out_coord_o, elem_count_o} !== 24'd0) begin
      n_fail++; $display("FAIL reset_data: coord %0d count %0d expected 0 0", out_coord_o, elem_count_o); end
    n_checks++; if (mrg_coord_in_o !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL reset_mrg_in: got %h expected ffffffff", mrg_coord_in_o); end
    reset_i = 1'b0;
  endtask

  task automatic test_basic_merge();
    load_case1();
    run_merge(4'hF, -1, 0, -1, 1, 0, 300);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
    n_checks++; if (beats.size() != 7) begin n_fail++; $display("FAIL basic_len: got %0d expected 7", beats.size()); end
    for (int k = 0; k < 7 && k < beats.size(); k++) begin
      n_checks++; if (beats[k] !== exp1[k] || lasts[k] !== (k == 6)) begin
        n_fail++; $display("FAIL basic_beat%0d: got %0d last %0b expected %0d last %0b", k, beats[k], lasts[k], exp1[k], k == 6); end
    end
    n_checks++; if (elem_count_o !== 16'd7 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_status: count %0d err %0b expected 7 0", elem_count_o, err_o); end
    n_checks++; if (done_cnt != 1 || done_after !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: pulses %0d done_after %0b expected 1 0", done_cnt, done_after); end
  endtask

  task automatic test_zero_length();
    load_case1();
    run_merge(4'h0, -1, 0, -1, 1, 0, 20);
    n_checks++; if (done_cyc < 0 || done_cyc > 3) begin
      n_fail++; $display("FAIL zero_done: done at cycle %0d expected 1..3", done_cyc); end
    n_checks++; if (valid_cnt != 0 || elem_count_o !== 16'd0) begin
      n_fail++; $display("FAIL zero_output: valid cycles %0d count %0d expected 0 0", valid_cnt, elem_count_o); end
  endtask

  task automatic test_backpressure();
    load_case1();
    run_merge(4'hF, 1, 5, -1, 1, 0, 300);
    n_checks++; if (stall_cycles != 5 || stall_coord !== 8'd2 || stall_bad != 0) begin
      n_fail++; $display("FAIL stall_hold: cycles %0d coord %0d bad %0d expected 5 2 0", stall_cycles, stall_coord, stall_bad); end
    n_checks++; if (beats.size() != 7) begin n_fail++; $display("FAIL stall_len: got %0d expected 7", beats.size()); end
    for (int k = 0; k < 7 && k < beats.size(); k++) begin
      n_checks++; if (beats[k] !== exp1[k]) begin
        n_fail++; $display("FAIL stall_beat%0d: got %0d expected %0d", k, beats[k], exp1[k]); end
    end
    n_checks++; if (elem_count_o !== 16'd7) begin n_fail++; $display("FAIL stall_count: got %0d expected 7", elem_count_o); end
  endtask

  task automatic test_sentinel();
    set_lane(0, 1, 8'd1, 8'd0); set_lane(1, 1, 8'hFF, 8'd0);
    set_lane(2, 1, 8'd3, 8'd0); set_lane(3, 1, 8'd4, 8'd0);
    run_merge(4'hF, -1, 0, -1, 1, 0, 50);
    n_checks++; if (err_o !== 1'b1 || done_cnt != 1) begin
      n_fail++; $display("FAIL sentinel_err: err %0b pulses %0d expected 1 1", err_o, done_cnt); end
    n_checks++; if (valid_cnt != 0 || elem_count_o !== 16'd0) begin
      n_fail++; $display("FAIL sentinel_nobeat: valid cycles %0d count %0d expected 0 0", valid_cnt, elem_count_o); end
  endtask

  task automatic test_ties_slow_lane();
    set_lane(0, 2, 8'd3, 8'd9); set_lane(1, 2, 8'd3, 8'd9);
    set_lane(2, 1, 8'd4, 8'd0); set_lane(3, 0, 8'd0, 8'd0);
    run_merge(4'b0111, -1, 0, 2, 3, 0, 300);
    n_checks++; if (beats.size() != 5) begin n_fail++; $display("FAIL tie_len: got %0d expected 5", beats.size()); end
    for (int k = 0; k < 5 && k < beats.size(); k++) begin
      n_checks++; if (beats[k] !== exp6[k] || lasts[k] !== (k == 4)) begin
        n_fail++; $display("FAIL tie_beat%0d: got %0d last %0b expected %0d last %0b", k, beats[k], lasts[k], exp6[k], k == 4); end
    end
    n_checks++; if (elem_count_o !== 16'd5 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL tie_status: count %0d err %0b expected 5 0", elem_count_o, err_o); end
  endtask

  task automatic test_reset_mid_merge();
    load_case1();
    run_merge(4'hF, -1, 0, -1, 1, 2, 300);
    n_checks++; if ({lane_ready_o, mrg_selected_o, out_valid_o, out_last_o, done_o, err_o} !== 9'd0) begin
      n_fail++; $display("FAIL abort_ctrl: got %b expected 0", {lane_ready_o, mrg_selected_o, out_valid_o, out_last_o, done_o, err_o}); end
    n_checks++; if ({out_coord_o, elem_count_o} !== 24'd0 || mrg_coord_in_o !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL abort_data: coord %0d count %0d mrg_in %h expected 0 0 ffffffff", out_coord_o, elem_count_o, mrg_coord_in_o); end
    reset_i = 1'b0;
    load_case1();
    run_merge(4'hF, -1, 0, -1, 1, 0, 300);
    n_checks++; if (beats.size() != 7 || elem_count_o !== 16'd7 || done_cnt != 1) begin
      n_fail++; $display("FAIL abort_rerun: beats %0d count %0d pulses %0d expected 7 7 1", beats.size(), elem_count_o, done_cnt); end
    for (int k = 0; k < 7 && k < beats.size(); k++) begin
      n_checks++; if (beats[k] !== exp1[k]) begin
        n_fail++; $display("FAIL abort_beat%0d: got %0d expected %0d", k, beats[k], exp1[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_merge();
    test_zero_length();
    test_backpressure();
    test_sentinel();
    test_ties_slow_lane();
    test_reset_mid_merge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
